// File: rtl/ghostsz_pkg.sv
// Shared GhostSZ constants and the FSM state encoding used by both codec directions.
package ghostsz_pkg;
  localparam int CODE_ESC   = 0;      // code value that announces a verbatim literal word
  localparam int DEF_RADIUS = 32768;  // default code bias

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CODE    = 2'd1,
    LITERAL = 2'd2,
    DRAIN   = 2'd3
  } state_e;
endpackage

// File: rtl/ghostsz_if.sv
// Input word stream and output sample stream of the GhostSZ decoder.
interface ghostsz_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_last);
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/ghostsz_recon_pipe.sv
// Two-stage reconstruction datapath: stage 1 registers delta*step (or a literal),
// stage 2 closes the Lorenzo recurrence. The stage-2 data register doubles as prev.
module ghostsz_recon_pipe
  import ghostsz_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CODE_W = 16,
  parameter int RADIUS = DEF_RADIUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_fire,
  input  logic                     i_lit,
  input  logic                     i_last,
  input  logic [DATA_W-1:0]        i_word,
  input  logic signed [DATA_W-1:0] i_step,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  output logic                     o_last,
  output logic                     o_stall
);
  logic [CODE_W-1:0]        w_code;
  logic signed [CODE_W:0]   w_delta;
  logic signed [DATA_W-1:0] w_delta_x;
  logic signed [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_sum;
  logic                     w_stall;

  logic                     r_s1_vld, r_s1_lit, r_s1_last;
  logic [DATA_W-1:0]        r_s1_val;
  logic [DATA_W-1:0]        r_data;
  logic                     r_vld, r_last;

  assign w_code    = i_word[CODE_W-1:0];
  assign w_delta   = $signed({1'b0, w_code}) - $signed((CODE_W+1)'(RADIUS));
  assign w_delta_x = DATA_W'(w_delta);
  assign w_prod    = w_delta_x * i_step;           // truncated to DATA_W, wraps
  assign w_sum     = r_data + r_s1_val;
  assign w_stall   = r_vld && !i_out_ready;

  // Stage 1: product or literal plus tags; frozen while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_lit  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_val  <= '0;
    end else if (!w_stall) begin
      r_s1_vld  <= i_fire;
      r_s1_lit  <= i_lit;
      r_s1_last <= i_fire && i_last;
      r_s1_val  <= i_lit ? i_word : w_prod;
    end
  end

  // Stage 2: prev + delta*step, or the literal; result is also the next prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else if (i_clear) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else if (!w_stall) begin
      r_vld  <= r_s1_vld;
      r_last <= r_s1_vld && r_s1_last;
      if (r_s1_vld) r_data <= r_s1_lit ? r_s1_val : w_sum;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_vld;
  assign o_last  = r_last;
  assign o_stall = w_stall;
endmodule

// File: rtl/ghostsz_decoder.sv
// GhostSZ decode stage: block FSM, sample counter and escape handling around
// the reconstruction pipe.
module ghostsz_decoder
  import ghostsz_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CODE_W = 16,
  parameter int RADIUS = DEF_RADIUS,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic [DATA_W-1:0] step,
  input  logic [LEN_W-1:0]  block_len,
  ghostsz_if.slave          bus,
  output logic              busy,
  output logic              done
);
  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_step;
  logic [LEN_W-1:0]  r_len, r_count;
  logic              r_done;

  logic w_stall, w_in_ready, w_accept, w_esc, w_lit, w_fire, w_last;
  logic w_begin, w_empty_blk, w_end_hs;

  assign w_esc       = (bus.in_data[CODE_W-1:0] == CODE_W'(CODE_ESC));
  assign w_lit       = (r_state == LITERAL);
  assign w_in_ready  = ((r_state == CODE) || (r_state == LITERAL)) && !w_stall;
  assign w_accept    = bus.in_valid && w_in_ready;
  // An escape word is consumed but produces nothing.
  assign w_fire      = w_accept && (w_lit || !w_esc);
  assign w_last      = (r_count == r_len - 1'b1);
  assign w_begin     = (r_state == IDLE) && start && (block_len != '0);
  assign w_empty_blk = (r_state == IDLE) && start && (block_len == '0);
  assign w_end_hs    = (r_state == DRAIN) && bus.out_valid && bus.out_ready && bus.out_last;

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: escape toggles CODE/LITERAL, last sample moves to DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_begin) w_state_nxt = CODE;
      CODE:    if (w_accept) begin
                 if (w_esc)       w_state_nxt = LITERAL;
                 else if (w_last) w_state_nxt = DRAIN;
               end
      LITERAL: if (w_accept) w_state_nxt = w_last ? DRAIN : CODE;
      DRAIN:   if (w_end_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Block context: step/len latched only at start, count advances per sample.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_step  <= '0;
      r_len   <= '0;
      r_count <= '0;
    end else if (w_begin) begin
      r_step  <= step;
      r_len   <= block_len;
      r_count <= '0;
    end else if (w_fire) begin
      r_count <= r_count + 1'b1;
    end
  end

  // done: one cycle after the last output handshake, or after an empty-block start.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_done <= 1'b0;
    else        r_done <= w_end_hs || w_empty_blk;
  end

  ghostsz_recon_pipe #(
    .DATA_W (DATA_W),
    .CODE_W (CODE_W),
    .RADIUS (RADIUS)
  ) u_pipe (
    .clk         (clk),
    .rst         (areset),
    .i_clear     (w_begin),
    .i_fire      (w_fire),
    .i_lit       (w_lit),
    .i_last      (w_last),
    .i_word      (bus.in_data),
    .i_step      (r_step),
    .i_out_ready (bus.out_ready),
    .o_data      (bus.out_data),
    .o_valid     (bus.out_valid),
    .o_last      (bus.out_last),
    .o_stall     (w_stall)
  );

  assign bus.in_ready = w_in_ready;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
endmodule

// File: doc/ghostsz_decoder.md
# ghostsz_decoder

Streaming GhostSZ reconstruction stage: it is the decode direction of the compressor's prediction/quantization path. It consumes a word stream of quantization codes with escaped literals and rebuilds fixed-point samples using an order-0 Lorenzo predictor, where the previous reconstructed sample is the prediction. It sits between the decompression input DMA stream and the fixed-to-float back-end, and sustains one word per clock.

## Interface
Parameters:
- DATA_W, 32, sample and input word width (two's complement)
- CODE_W, 16, quantization code width, taken from in_data[CODE_W-1:0]
- RADIUS, 32768, code bias; delta = code - RADIUS
- LEN_W, 16, block length counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- start  in  1  pulse; latches step/block_len and begins a block (ignored unless IDLE)
- step  in  DATA_W  signed quantization step (2*eb in fixed-point LSBs)
- block_len  in  LEN_W  samples in block
- in_data  in  DATA_W  code word or literal word
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- out_data  out  DATA_W  reconstructed sample
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accepts
- out_last  out  1  final sample of block, qualified by out_valid
- busy  out  1  block in progress
- done  out  1  one-cycle pulse after the last sample is accepted downstream

## Operation
- States: IDLE, CODE, LITERAL, DRAIN.
- IDLE + start with block_len != 0: latch step and block_len, prev = 0, count = 0, go to CODE. With block_len == 0, pulse done the next cycle and stay IDLE.
- CODE, accepted word, code != 0: delta = code - RADIUS (signed, CODE_W+1 bits). Sample = prev + delta*step, truncated to DATA_W and wrapping. prev is updated with the sample.
- CODE, accepted word, code == 0 (escape): no sample is produced, go to LITERAL.
- LITERAL, accepted word: sample = in_data verbatim, prev = in_data, return to CODE.
- Every produced sample increments count. When the sample with count == block_len-1 enters the pipeline, it is tagged last and the FSM goes to DRAIN. In DRAIN, in_ready = 0.
- DRAIN: once the last sample is accepted downstream, done pulses and the FSM returns to IDLE. busy = (state != IDLE).
- Backpressure: stall = out_valid && !out_ready. The whole pipeline holds while stalled. in_ready = (state is CODE or LITERAL) && !stall. This path from out_ready to in_ready is combinational and permitted.
- Upper bits of a code word above CODE_W are ignored.
- start while busy is ignored. Changes to step or block_len while busy have no effect.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, state IDLE, prev 0, count 0.
- Stage 1 registers the product delta*step, or the literal, plus a last tag.
- Stage 2 adds prev, except for literals, and drives out_data/out_valid.
- Latency: 2 cycles from input accept to out_valid.
- The prev recurrence closes in stage 2 with a single adder, so back-to-back codes give 1 sample/cycle.
- An escape word costs one input cycle with no output.
- done is asserted the cycle after the out_last handshake. busy falls in the same cycle.
- areset mid-block discards all in-flight samples. Outputs return to reset values immediately, and the decoder needs a new start.

## Structure
- Package ghostsz_pkg: CODE_ESC = 0, default RADIUS, and the state enum (IDLE/CODE/LITERAL/DRAIN). The same enum style is shared with the encoder side.
- One sub-module, ghostsz_recon_pipe, holds the two-stage multiply/add datapath with stall and prev. The FSM and counter stay in ghostsz_decoder.

## Test plan
- step=4, block_len=3, codes 32769, 32769, 32766, out_ready=1 → out_data 4, 8, 0 on consecutive cycles; out_last on third; done one cycle later.
- step=4, block_len=2, words 0, 0x00001234, 32768 → out_data 0x1234, 0x1234; no output for the escape word.
- Wrap-around: literal 0x7FFFFFFC, then code 32770 with step=4 → 0x7FFFFFFC, 0x80000004.
- Backpressure: out_ready low for 5 cycles mid-stream → out_data held stable, in_ready low, no sample lost or duplicated, sequence matches the unstalled run.
- block_len=0 start → done pulse, no out_valid, busy stays 0.
- areset asserted with 2 samples in flight → out_valid/busy drop at once; new start with step=1, code 32769 → out_data 1, proving prev was cleared.
